fp_mul_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 multiplier for the FPU datapath. It is the successor to the combinational single-precision multiplier. It adds configurable exponent and mantissa widths and a 3-stage valid/ready pipeline with backpressure. It also provides correct directed rounding (including overflow-to-max-finite) and a full exception-flag set. It sits between the FPU operand-issue logic and the result writeback arbiter.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fp_round_pack.sv | 76 +++++++
 rtl/fp_mul_pipe.sv | 142 ++++++++++++++
 tb/tb_fp_mul_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, flag bit positions, operand
// classes and a helper that builds special-value bit patterns for any format.
package fpu_pkg;

    localparam logic [1:0] RM_POS_INF = 2'b00;
    localparam logic [1:0] RM_NEG_INF = 2'b01;
    localparam logic [1:0] RM_RNE     = 2'b10;
    localparam logic [1:0] RM_RTZ     = 2'b11;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    typedef enum logic [1:0] {PAT_NAN, PAT_INF, PAT_MAX_FINITE} fp_pat_e;

    // Result is right-aligned in 64 bits; callers truncate to 1+exp_w+man_w.
    function automatic logic [63:0] fp_special_pat(input fp_pat_e kind, input logic sign,
                                                   input int exp_w, input int man_w);
        logic [63:0] exp_ones;
        logic [63:0] man_ones;
        logic [63:0] sgn;
        exp_ones = (64'd1 << exp_w) - 64'd1;
        man_ones = (64'd1 << man_w) - 64'd1;
        sgn      = {63'd0, sign} << (exp_w + man_w);
        case (kind)
            PAT_NAN: return (exp_ones << man_w) | (64'd1 << (man_w - 1));
            PAT_INF: return sgn | (exp_ones << man_w);
            default: return sgn | ((exp_ones - 64'd1) << man_w) | man_ones;
        endcase
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round and pack a raw mantissa product with its biased exponent.
// Purely combinational so it can sit in the last stage of any FP pipeline.
module fp_round_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     sign,
    input  logic [1:0]               round_mode,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [2*MAN_W+1:0]       prod,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

    logic [PW-1:0]          norm;
    logic [MAN_W:0]         mant;
    logic                   guard;
    logic                   sticky;
    logic                   inc;
    logic                   to_inf;
    logic [MAN_W+1:0]       mant_r;
    logic [MAN_W-1:0]       frac;
    logic signed [EW-1:0]   e_n;
    logic signed [EW-1:0]   e_f;

    always_comb begin
        result = '0;
        flags  = '0;
        to_inf = 1'b0;
        inc    = 1'b0;

        // Product lies in [1,4); bring the leading one to the top bit.
        norm   = prod[PW-1] ? prod : (prod << 1);
        e_n    = exp_in + $signed({{(EW-1){1'b0}}, prod[PW-1]});
        mant   = norm[PW-1 -: MAN_W+1];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];

        case (round_mode)
            RM_RNE:     inc = guard & (sticky | mant[0]);
            RM_POS_INF: inc = !sign & (guard | sticky);
            RM_NEG_INF: inc = sign & (guard | sticky);
            default:    inc = 1'b0;
        endcase

        mant_r = {1'b0, mant} + (MAN_W+2)'(inc);
        e_f    = e_n + $signed({{(EW-1){1'b0}}, mant_r[MAN_W+1]});
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        if (e_f >= EXP_MAX) begin
            to_inf = (round_mode == RM_RNE)
                   | ((round_mode == RM_POS_INF) & !sign)
                   | ((round_mode == RM_NEG_INF) & sign);
            result = to_inf ? FW'(fp_special_pat(PAT_INF, sign, EXP_W, MAN_W))
                            : FW'(fp_special_pat(PAT_MAX_FINITE, sign, EXP_W, MAN_W));
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (e_f <= EXP_ZERO) begin
            result = {sign, {(FW-1){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            result = {sign, e_f[EXP_W-1:0], frac};
            flags[FLAG_INEXACT] = guard | sticky;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (decode / multiply / round) with a
// single global stall driven by the output handshake.
module fp_mul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             round_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '1) return (f != '0) ? NAN : INF;
        if (e == '0) return ZERO;
        return NORM;
    endfunction

    logic                 adv;
    fp_class_e            cls_a, cls_b;
    logic                 sign_in;
    logic                 spec_in;
    logic [FW-1:0]        spec_res_in;
    logic [3:0]           spec_flg_in;

    logic                 v1_q, v1_d, sign1_q, sign1_d, spec1_q, spec1_d;
    logic [FW-1:0]        spec_res1_q, spec_res1_d;
    logic [3:0]           spec_flg1_q, spec_flg1_d;
    logic signed [EW-1:0] exp1_q, exp1_d;
    logic [MAN_W:0]       ma1_q, ma1_d, mb1_q, mb1_d;
    logic [1:0]           rm1_q, rm1_d;

    logic                 v2_q, v2_d, sign2_q, sign2_d, spec2_q, spec2_d;
    logic [FW-1:0]        spec_res2_q, spec_res2_d;
    logic [3:0]           spec_flg2_q, spec_flg2_d;
    logic signed [EW-1:0] exp2_q, exp2_d;
    logic [PW-1:0]        prod2_q, prod2_d;
    logic [1:0]           rm2_q, rm2_d;

    logic                 out_valid_q, out_valid_d;
    logic [FW-1:0]        result_q, result_d, rp_result;
    logic [3:0]           flags_q, flags_d, rp_flags;

    assign adv       = !out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Special operands resolve fully in S1 and ride the pipe as a bypass result.
    always_comb begin
        cls_a       = classify(a[FW-2 -: EXP_W], a[MAN_W-1:0]);
        cls_b       = classify(b[FW-2 -: EXP_W], b[MAN_W-1:0]);
        sign_in     = a[FW-1] ^ b[FW-1];
        spec_in     = 1'b1;
        spec_res_in = '0;
        spec_flg_in = '0;
        if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == INF)
            || (cls_a == INF && cls_b == ZERO)) begin
            spec_res_in = FW'(fp_special_pat(PAT_NAN, 1'b0, EXP_W, MAN_W));
            spec_flg_in[FLAG_INVALID] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            spec_res_in = FW'(fp_special_pat(PAT_INF, sign_in, EXP_W, MAN_W));
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            spec_res_in = {sign_in, {(FW-1){1'b0}}};
        end else begin
            spec_in = 1'b0;
        end
    end

    always_comb begin
        v1_d = v1_q; sign1_d = sign1_q; spec1_d = spec1_q; spec_res1_d = spec_res1_q;
        spec_flg1_d = spec_flg1_q; exp1_d = exp1_q; ma1_d = ma1_q; mb1_d = mb1_q; rm1_d = rm1_q;
        v2_d = v2_q; sign2_d = sign2_q; spec2_d = spec2_q; spec_res2_d = spec_res2_q;
        spec_flg2_d = spec_flg2_q; exp2_d = exp2_q; prod2_d = prod2_q; rm2_d = rm2_q;
        out_valid_d = out_valid_q; result_d = result_q; flags_d = flags_q;
        if (adv) begin
            v1_d        = in_valid;
            sign1_d     = sign_in;
            spec1_d     = spec_in;
            spec_res1_d = spec_res_in;
            spec_flg1_d = spec_flg_in;
            exp1_d      = $signed({2'b00, a[FW-2 -: EXP_W]}) + $signed({2'b00, b[FW-2 -: EXP_W]}) - BIAS;
            ma1_d       = {1'b1, a[MAN_W-1:0]};
            mb1_d       = {1'b1, b[MAN_W-1:0]};
            rm1_d       = round_mode;

            v2_d        = v1_q;
            sign2_d     = sign1_q;
            spec2_d     = spec1_q;
            spec_res2_d = spec_res1_q;
            spec_flg2_d = spec_flg1_q;
            exp2_d      = exp1_q;
            prod2_d     = PW'(ma1_q) * PW'(mb1_q);
            rm2_d       = rm1_q;

            out_valid_d = v2_q;
            result_d    = spec2_q ? spec_res2_q : rp_result;
            flags_d     = spec2_q ? spec_flg2_q : rp_flags;
        end
    end

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
        .sign       (sign2_q),
        .round_mode (rm2_q),
        .exp_in     (exp2_q),
        .prod       (prod2_q),
        .result     (rp_result),
        .flags      (rp_flags)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0; sign1_q <= 1'b0; spec1_q <= 1'b0; spec_res1_q <= '0;
            spec_flg1_q <= '0; exp1_q <= '0; ma1_q <= '0; mb1_q <= '0; rm1_q <= '0;
            v2_q <= 1'b0; sign2_q <= 1'b0; spec2_q <= 1'b0; spec_res2_q <= '0;
            spec_flg2_q <= '0; exp2_q <= '0; prod2_q <= '0; rm2_q <= '0;
            out_valid_q <= 1'b0; result_q <= '0; flags_q <= '0;
        end else begin
            v1_q <= v1_d; sign1_q <= sign1_d; spec1_q <= spec1_d; spec_res1_q <= spec_res1_d;
            spec_flg1_q <= spec_flg1_d; exp1_q <= exp1_d; ma1_q <= ma1_d; mb1_q <= mb1_d; rm1_q <= rm1_d;
            v2_q <= v2_d; sign2_q <= sign2_d; spec2_q <= spec2_d; spec_res2_q <= spec_res2_d;
            spec_flg2_q <= spec_flg2_d; exp2_q <= exp2_d; prod2_q <= prod2_d; rm2_q <= rm2_d;
            out_valid_q <= out_valid_d; result_q <= result_d; flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single and double precision instances.
module tb_fp_mul_pipe;

    localparam logic [1:0] POS = 2'b00, NEG = 2'b01, RNE = 2'b10, RTZ = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [1:0]  round_mode;
    logic [3:0]  flags;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] a64, b64, result64;
    logic [1:0]  round_mode64;
    logic [3:0]  flags64;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    fp_mul_pipe #(.EXP_W(11), .MAN_W(52)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .round_mode(round_mode64), .out_valid(out_valid64),
        .out_ready(out_ready64), .result(result64), .flags(flags64)
    );

    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic [1:0] rm,
                          output logic [31:0] r, output logic [3:0] f, output int lat, output logic to);
        int wait_cnt;
        @(negedge clk);
        a = op_a; b = op_b; round_mode = rm; in_valid = 1'b1; out_ready = 1'b1;
        wait_cnt = 0;
        #1;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk); #1; wait_cnt++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        to = !out_valid;
        r = result;
        f = flags;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || flags !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b result=%h flags=%b, want 0 1 00000000 0000",
                     out_valid, in_ready, result, flags);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] r; logic [3:0] f; int lat; logic to;
        run_op(32'h3FC00000, 32'h40000000, RNE, r, f, lat, to);
        tests_run++;
        if (to || r !== 32'h40400000 || f !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic_1p5x2: got %h/%b timeout=%b, want 40400000/0000", r, f, to);
        end
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, want 3", lat);
        end
        run_op(32'hBFC00000, 32'h40000000, RNE, r, f, lat, to);
        tests_run++;
        if (to || r !== 32'hC0400000 || f !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic_neg: got %h/%b timeout=%b, want C0400000/0000", r, f, to);
        end
    endtask

    task automatic test_rounding;
        logic [31:0] ta[6], tb_[6], te[6];
        logic [1:0]  tr[6];
        logic [31:0] r; logic [3:0] f; int lat; logic to;
        ta = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'hBF800001, 32'hBF800001};
        tb_ = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001};
        tr = '{RNE, POS, RTZ, NEG, NEG, POS};
        te = '{32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3F800002, 32'hBF800003, 32'hBF800002};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb_[i], tr[i], r, f, lat, to);
            tests_run++;
            if (to || r !== te[i] || f !== 4'b0001) begin
                tests_failed++;
                $display("FAIL rounding[%0d]: got %h/%b timeout=%b, want %h/0001", i, r, f, to, te[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] ta[6], te[6];
        logic [1:0]  tr[6];
        logic [31:0] r; logic [3:0] f; int lat; logic to;
        ta = '{32'h7F000000, 32'h7F000000, 32'hFF000000, 32'h7F000000, 32'hFF000000, 32'h7F000000};
        tr = '{RNE, RTZ, POS, NEG, NEG, POS};
        te = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 32'h7F800000};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], 32'h7F000000, tr[i], r, f, lat, to);
            tests_run++;
            if (to || r !== te[i] || f !== 4'b0101) begin
                tests_failed++;
                $display("FAIL overflow[%0d]: got %h/%b timeout=%b, want %h/0101", i, r, f, to, te[i]);
            end
        end
    endtask

    task automatic test_specials;
        logic [31:0] ta[7], tb_[7], te[7];
        logic [3:0]  tf[7];
        logic [31:0] r; logic [3:0] f; int lat; logic to;
        ta  = '{32'h7F800000, 32'h00400000, 32'h00800000, 32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h00000000};
        tb_ = '{32'h00000000, 32'h3F800000, 32'h00800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'hFF800000};
        te  = '{32'h7FC00000, 32'h00000000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000};
        tf  = '{4'b1000, 4'b0000, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb_[i], RNE, r, f, lat, to);
            tests_run++;
            if (to || r !== te[i] || f !== tf[i]) begin
                tests_failed++;
                $display("FAIL specials[%0d]: got %h/%b timeout=%b, want %h/%b", i, r, f, to, te[i], tf[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta[6], te[6];
        logic [31:0] held;
        int sent, got, cyc;
        logic held_set;
        ta = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        te = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};
        sent = 0; got = 0; cyc = 0; held_set = 1'b0; held = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= 8);
            round_mode = RNE;
            b = 32'h40000000;
            if (sent < 6) begin a = ta[sent]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (cyc == 7) begin
                tests_run++;
                if (sent !== 3 || in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_accepts: accepted=%0d in_ready=%b, want 3 0", sent, in_ready);
                end
            end
            if (out_valid && !out_ready) begin
                if (!held_set) begin held = result; held_set = 1'b1; end
                else begin
                    tests_run++;
                    if (result !== held) begin
                        tests_failed++;
                        $display("FAIL stall_stable: result=%h, held value %h", result, held);
                    end
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                tests_run++;
                if (result !== te[got]) begin
                    tests_failed++;
                    $display("FAIL order[%0d]: got %h, want %h", got, result, te[got]);
                end
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got !== 6 || held !== te[0]) begin
            tests_failed++;
            $display("FAIL b2b_complete: results=%0d held=%h, want 6 %h", got, held, te[0]);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] r; logic [3:0] f; int lat; logic to;
        int seen;
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h40000000; round_mode = RNE; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h40000000;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midflight_reset_valid: out_valid=%b, want 0", out_valid);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midflight_discard: %0d stale results, want 0", seen);
        end
        run_op(32'h40400000, 32'h40000000, RNE, r, f, lat, to);
        tests_run++;
        if (to || r !== 32'h40C00000 || lat !== 3) begin
            tests_failed++;
            $display("FAIL post_reset_op: got %h lat=%0d timeout=%b, want 40C00000 lat=3", r, lat, to);
        end
    endtask

    task automatic test_double;
        int lat;
        @(negedge clk);
        a64 = 64'h3FF8000000000000; b64 = 64'h4000000000000000; round_mode64 = RNE;
        in_valid64 = 1'b1; out_ready64 = 1'b1;
        @(negedge clk);
        in_valid64 = 1'b0;
        lat = 1;
        #1;
        while (!out_valid64 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        tests_run++;
        if (!out_valid64 || result64 !== 64'h4008000000000000 || flags64 !== 4'b0000 || lat !== 3) begin
            tests_failed++;
            $display("FAIL double_1p5x2: got %h/%b lat=%0d valid=%b, want 4008000000000000/0000 lat=3",
                     result64, flags64, lat, out_valid64);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; round_mode = RNE;
        in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0; round_mode64 = RNE;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_rounding;
        test_overflow;
        test_specials;
        test_back_to_back;
        test_reset_midflight;
        test_double;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
